// File: rtl/reg_file_wb_if.sv
// ---------------------------------------------------------------------------
// reg_file_wb_if
//   Bundles the register-file signals exchanged between the pipeline
//   (decode operand fetch + write-back select + fetch PC load) and the
//   16-entry ARM register file.
//
//   Signals (names kept from the original flat port list):
//     readAddr1/readAddr2   read indices (Rn, Rm)
//     readData1/readData2   combinational read data
//     writeAddr/writeData   write-back index and value
//     writeEnable           write strobe, already condition/opcode gated
//     pcIn                  address of the current instruction
//     pcLoad/pcLoadValue    registered one-cycle PC load request to fetch
//
//   Modports:
//     master  pipeline side (drives addresses, write-back and pcIn)
//     slave   register file side (drives read data and PC load request)
// ---------------------------------------------------------------------------
interface reg_file_wb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);

    logic [ADDR_WIDTH-1:0] readAddr1;
    logic [ADDR_WIDTH-1:0] readAddr2;
    logic [DATA_WIDTH-1:0] readData1;
    logic [DATA_WIDTH-1:0] readData2;
    logic [ADDR_WIDTH-1:0] writeAddr;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  writeEnable;
    logic [DATA_WIDTH-1:0] pcIn;
    logic                  pcLoad;
    logic [DATA_WIDTH-1:0] pcLoadValue;

    modport master (
        output readAddr1,
        output readAddr2,
        output writeAddr,
        output writeData,
        output writeEnable,
        output pcIn,
        input  readData1,
        input  readData2,
        input  pcLoad,
        input  pcLoadValue
    );

    modport slave (
        input  readAddr1,
        input  readAddr2,
        input  writeAddr,
        input  writeData,
        input  writeEnable,
        input  pcIn,
        output readData1,
        output readData2,
        output pcLoad,
        output pcLoadValue
    );

endinterface

// File: rtl/reg_file_wb.sv
// ---------------------------------------------------------------------------
// reg_file_wb
//   16-entry ARM register file fed by the write-back select stage.
//   R0..R14 are stored in flops; R15 is virtual:
//     - reads of R15 return pcIn + PC_OFFSET (wrapping),
//     - writes to R15 never touch the array; they raise a registered,
//       single-cycle pcLoad request carrying the word-aligned target.
//   Reads are combinational with a same-cycle write-through bypass.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset (R0..R14, pcLoad, pcLoadValue -> 0;
//            a write in the reset cycle is discarded)
//     bus    reg_file_wb_if.slave (read ports, write port, pcIn, pcLoad*)
// ---------------------------------------------------------------------------
module reg_file_wb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 16,
    parameter int PC_OFFSET  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_file_wb_if.slave     bus
);

    // Only R0..R(NUM_REGS-2) have storage; the top index is the PC.
    localparam int unsigned           NUM_STORED = NUM_REGS - 1;
    localparam logic [ADDR_WIDTH-1:0] PC_IDX     = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [DATA_WIDTH-1:0] PC_OFS     = DATA_WIDTH'(PC_OFFSET);

    typedef logic [NUM_STORED-1:0][DATA_WIDTH-1:0] reg_array_t;

    reg_array_t            regs_q;
    reg_array_t            regs_d;
    logic                  pc_load_q;
    logic                  pc_load_d;
    logic [DATA_WIDTH-1:0] pc_load_value_q;
    logic [DATA_WIDTH-1:0] pc_load_value_d;

    logic                  wr_pc;
    logic                  wr_array;
    logic [DATA_WIDTH-1:0] wr_pc_target;

    // One read port: PC view first, then bypass, then stored value.
    // The array is selected by comparison rather than indexing so that
    // the virtual PC index never addresses a non-existent entry.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  we,
        input logic [ADDR_WIDTH-1:0] waddr,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [DATA_WIDTH-1:0] pc,
        input reg_array_t            regs
    );
        logic [DATA_WIDTH-1:0] result;
        result = '0;
        for (int unsigned i = 0; i < NUM_STORED; i++) begin
            if (addr == ADDR_WIDTH'(i)) begin
                result = regs[i];
            end
        end
        if (we && (addr == waddr)) begin
            result = wdata;
        end
        if (addr == PC_IDX) begin
            result = pc + PC_OFS;
        end
        return result;
    endfunction

    // Write decode. writeEnable gates every address comparison, so an
    // unknown writeAddr with writeEnable=0 cannot disturb state.
    always_comb begin
        wr_pc        = 1'b0;
        wr_array     = 1'b0;
        wr_pc_target = {bus.writeData[DATA_WIDTH-1:2], 2'b00};
        if (bus.writeEnable) begin
            if (bus.writeAddr == PC_IDX) begin
                wr_pc = 1'b1;
            end else begin
                wr_array = 1'b1;
            end
        end
    end

    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 0; i < NUM_STORED; i++) begin
            if (wr_array && (bus.writeAddr == ADDR_WIDTH'(i))) begin
                regs_d[i] = bus.writeData;
            end
        end
    end

    // pcLoad is a pulse: it follows this cycle's R15 write strobe, so it
    // drops on any edge without one. The target is held otherwise.
    always_comb begin
        pc_load_d       = wr_pc;
        pc_load_value_d = pc_load_value_q;
        if (wr_pc) begin
            pc_load_value_d = wr_pc_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q          <= '0;
            pc_load_q       <= 1'b0;
            pc_load_value_q <= '0;
        end else begin
            regs_q          <= regs_d;
            pc_load_q       <= pc_load_d;
            pc_load_value_q <= pc_load_value_d;
        end
    end

    assign bus.readData1   = read_port(bus.readAddr1, bus.writeEnable, bus.writeAddr,
                                       bus.writeData, bus.pcIn, regs_q);
    assign bus.readData2   = read_port(bus.readAddr2, bus.writeEnable, bus.writeAddr,
                                       bus.writeData, bus.pcIn, regs_q);
    assign bus.pcLoad      = pc_load_q;
    assign bus.pcLoadValue = pc_load_value_q;

endmodule

// File: tb/tb_reg_file_wb.sv
module tb_reg_file_wb;

    localparam int DW = 32;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    reg_file_wb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    reg_file_wb #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_REGS  (16),
        .PC_OFFSET (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // Architectural view: 15 stored registers plus the pending PC load.
    logic [31:0] m_regs[15];
    bit          m_pl    = 1'b0;
    logic [31:0] m_pv    = 32'h0;
    bit          m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [3:0] a);
        if (a == 4'd15) return bus.pcIn + 32'd8;
        if (bus.writeEnable && (a == bus.writeAddr)) return bus.writeData;
        return m_regs[a];
    endfunction

    // Reference model update on each active edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            foreach (m_regs[i]) m_regs[i] = 32'h0;
            m_pl    = 1'b0;
            m_pv    = 32'h0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_pl = bus.writeEnable && (bus.writeAddr == 4'd15);
            if (m_pl) m_pv = {bus.writeData[31:2], 2'b00};
            if (bus.writeEnable && (bus.writeAddr != 4'd15))
                m_regs[bus.writeAddr] = bus.writeData;
        end
    end

    // Compare process: inputs change at negedge+1, sample at negedge+3.
    always @(negedge clk) begin
        #3;
        if (m_valid) begin
            check("rd1", bus.readData1, exp_read(bus.readAddr1));
            check("rd2", bus.readData2, exp_read(bus.readAddr2));
            check("pcLoad", 32'(bus.pcLoad), 32'(m_pl));
            if (m_pl) check("pcLoadValue", bus.pcLoadValue, m_pv);
            check("xfree", 32'($isunknown({bus.readData1, bus.readData2,
                                           bus.pcLoad, bus.pcLoadValue})), 32'h0);
        end
    end

    task automatic cyc(input bit rn, input bit we, input logic [3:0] wa,
                       input logic [31:0] wd, input logic [3:0] a1,
                       input logic [3:0] a2, input logic [31:0] pc);
        @(negedge clk);
        #1;
        rst_n           = rn;
        bus.writeEnable = we;
        bus.writeAddr   = wa;
        bus.writeData   = wd;
        bus.readAddr1   = a1;
        bus.readAddr2   = a2;
        bus.pcIn        = pc;
    endtask

    initial begin
        logic [3:0] wa;
        rst_n           = 1'b0;
        bus.writeEnable = 1'b0;
        bus.writeAddr   = 4'd0;
        bus.writeData   = 32'h0;
        bus.readAddr1   = 4'd0;
        bus.readAddr2   = 4'd0;
        bus.pcIn        = 32'h0;
        cyc(0, 0, 4'd0, 32'h0, 4'd0, 4'd0, 32'h0);

        // Reset clears a preloaded register
        cyc(1, 1, 4'd3, 32'hDEADBEEF, 4'd0, 4'd0, 32'h0);
        cyc(1, 0, 4'd0, 32'h0, 4'd3, 4'd0, 32'h0);
        #2 check("t1_preload", bus.readData1, 32'hDEADBEEF);
        cyc(0, 0, 4'd0, 32'h0, 4'd3, 4'd0, 32'h0);
        cyc(1, 0, 4'd0, 32'h0, 4'd3, 4'd0, 32'h0);
        #2 check("t1_r3_after_reset", bus.readData1, 32'h0);
        check("t1_pcload_reset", 32'(bus.pcLoad), 32'h0);
        check("t1_pcloadvalue_reset", bus.pcLoadValue, 32'h0);

        // Write with same-cycle bypass, then through the array
        cyc(1, 1, 4'd5, 32'h12345678, 4'd5, 4'd0, 32'h0);
        #2 check("t2_bypass", bus.readData1, 32'h12345678);
        cyc(1, 0, 4'd5, 32'h0, 4'd5, 4'd5, 32'h0);
        #2 check("t2_array", bus.readData1, 32'h12345678);
        check("t2_array_p2", bus.readData2, 32'h12345678);

        // PC read and wrap
        cyc(1, 0, 4'd0, 32'h0, 4'd0, 4'd15, 32'h100);
        #2 check("t3_pc_read", bus.readData2, 32'h108);
        cyc(1, 0, 4'd0, 32'h0, 4'd0, 4'd15, 32'hFFFFFFFC);
        #2 check("t3_pc_wrap", bus.readData2, 32'h4);

        // PC write: registered aligned load, single-cycle pulse
        cyc(1, 1, 4'd15, 32'h203, 4'd15, 4'd0, 32'h100);
        #2 check("t4_r15_read_during_write", bus.readData1, 32'h108);
        check("t4_no_early_pcload", 32'(bus.pcLoad), 32'h0);
        cyc(1, 0, 4'd0, 32'h0, 4'd15, 4'd0, 32'h100);
        #2 check("t4_pcload", 32'(bus.pcLoad), 32'h1);
        check("t4_pcloadvalue", bus.pcLoadValue, 32'h200);
        cyc(1, 0, 4'd0, 32'h0, 4'd15, 4'd0, 32'h100);
        #2 check("t4_pcload_clear", 32'(bus.pcLoad), 32'h0);
        check("t4_r15_read", bus.readData1, 32'h108);

        // Back-to-back R15 writes
        cyc(1, 1, 4'd15, 32'h1000, 4'd0, 4'd0, 32'h0);
        cyc(1, 1, 4'd15, 32'h2007, 4'd0, 4'd0, 32'h0);
        #2 check("b2b_first", bus.pcLoadValue, 32'h1000);
        cyc(1, 0, 4'd0, 32'h0, 4'd0, 4'd0, 32'h0);
        #2 check("b2b_held", 32'(bus.pcLoad), 32'h1);
        check("b2b_second", bus.pcLoadValue, 32'h2004);
        cyc(1, 0, 4'd0, 32'h0, 4'd0, 4'd0, 32'h0);
        #2 check("b2b_clear", 32'(bus.pcLoad), 32'h0);

        // Gated write: no update, no bypass
        cyc(1, 0, 4'd7, 32'hFFFF, 4'd7, 4'd7, 32'h0);
        #2 check("t5_no_bypass", bus.readData1, 32'h0);
        cyc(1, 0, 4'd0, 32'h0, 4'd7, 4'd0, 32'h0);
        #2 check("t5_r7_unchanged", bus.readData1, 32'h0);

        // Reset beats a simultaneous write
        cyc(0, 1, 4'd2, 32'h55, 4'd2, 4'd0, 32'h0);
        cyc(1, 0, 4'd0, 32'h0, 4'd2, 4'd0, 32'h0);
        #2 check("t6_r2_discarded", bus.readData1, 32'h0);
        cyc(0, 1, 4'd15, 32'h400, 4'd0, 4'd0, 32'h0);
        cyc(1, 0, 4'd0, 32'h0, 4'd0, 4'd0, 32'h0);
        #2 check("t6_pcload_under_reset", 32'(bus.pcLoad), 32'h0);

        // A pending pcLoad does not survive a reset
        cyc(1, 1, 4'd15, 32'h800, 4'd0, 4'd0, 32'h0);
        cyc(0, 0, 4'd0, 32'h0, 4'd0, 4'd0, 32'h0);
        #2 check("stale_pending", 32'(bus.pcLoad), 32'h1);
        cyc(1, 0, 4'd0, 32'h0, 4'd0, 4'd0, 32'h0);
        #2 check("stale_cleared", 32'(bus.pcLoad), 32'h0);

        // Randomized traffic; the compare process checks every cycle
        repeat (3000) begin
            wa = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            cyc(($urandom_range(0, 63) != 0),
                ($urandom_range(0, 2) != 0),
                wa,
                $urandom,
                ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)),
                $urandom);
        end

        @(negedge clk);
        #4;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
